// File: rtl/level_sequencer.sv
// Level sequencer: loads per-level start coordinates from a level ROM, holds the
// coin-manager refresh strobes across a vs frame edge, and tracks win/death/level flow.
module level_sequencer #(
    parameter int NUM_LEVELS = 4,
    parameter int ROM_LAT    = 1
) (
    input  logic        Clk,
    input  logic        RESET_N,
    input  logic        start,
    input  logic        vs,
    input  logic        player_dead,
    input  logic        player_in_goal,
    input  logic        collected_all,
    output logic [7:0]  rom_addr,
    input  logic [4:0]  rom_data,
    output logic [4:0]  player_start_x,
    output logic [4:0]  player_start_y,
    output logic [29:0] coin_start_x,
    output logic [29:0] coin_start_y,
    output logic        initialize_level,
    output logic        new_level,
    output logic [3:0]  level_num,
    output logic [15:0] death_count,
    output logic        busy,
    output logic        game_complete
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_PLAY, S_DEATH, S_ADVANCE, S_DONE
    } state_t;

    // Capture of ROM word idx happens ROM_LAT cycles after its address is driven;
    // LOAD ends on the capture of idx 13.
    localparam logic [4:0] LOAD_FIRST_CAP = 5'(ROM_LAT);
    localparam logic [4:0] LOAD_LAST      = 5'(13 + ROM_LAT);
    localparam logic [3:0] LAST_LEVEL     = 4'(NUM_LEVELS - 1);

    state_t      state_reg;
    logic [4:0]  load_cnt_reg;
    logic        tick_seen_reg;
    logic [7:0]  rom_addr_reg;
    logic [3:0]  level_reg;
    logic [15:0] death_reg;
    logic        init_reg;
    logic        new_level_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [4:0]  player_x_reg;
    logic [4:0]  player_y_reg;

    logic        vs_meta_reg;
    logic        vs_sync_reg;
    logic        vs_prev_reg;
    logic        frame_tick_reg;

    logic        cap_en;
    logic [3:0]  cap_idx;

    assign cap_en  = (state_reg == S_LOAD) && (load_cnt_reg >= LOAD_FIRST_CAP);
    assign cap_idx = 4'(load_cnt_reg - LOAD_FIRST_CAP);

    // vs crosses in through two flops; a registered rising-edge detect gives a 1-cycle frame tick.
    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_meta_reg    <= 1'b0;
            vs_sync_reg    <= 1'b0;
            vs_prev_reg    <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            vs_meta_reg    <= vs;
            vs_sync_reg    <= vs_meta_reg;
            vs_prev_reg    <= vs_sync_reg;
            frame_tick_reg <= vs_sync_reg & ~vs_prev_reg;
        end
    end

    // Game-flow FSM with all control outputs registered alongside the state.
    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= S_IDLE;
            load_cnt_reg  <= 5'd0;
            tick_seen_reg <= 1'b0;
            rom_addr_reg  <= 8'd0;
            level_reg     <= 4'd0;
            death_reg     <= 16'd0;
            init_reg      <= 1'b0;
            new_level_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_reg    <= S_LOAD;
                        level_reg    <= 4'd0;
                        death_reg    <= 16'd0;
                        rom_addr_reg <= 8'd0;
                        load_cnt_reg <= 5'd0;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    load_cnt_reg <= load_cnt_reg + 5'd1;
                    if (load_cnt_reg < 5'd13) begin
                        rom_addr_reg <= {level_reg, load_cnt_reg[3:0] + 4'd1};
                    end
                    if (load_cnt_reg == LOAD_LAST) begin
                        state_reg     <= S_INIT;
                        init_reg      <= 1'b1;
                        tick_seen_reg <= 1'b0;
                    end
                end
                S_INIT: begin
                    // Two ticks guarantee a full vs rising edge falls inside the pulse.
                    if (frame_tick_reg) begin
                        if (tick_seen_reg) begin
                            state_reg <= S_PLAY;
                            init_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                        end else begin
                            tick_seen_reg <= 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (frame_tick_reg) begin
                        if (player_dead) begin
                            state_reg     <= S_DEATH;
                            new_level_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                            tick_seen_reg <= 1'b0;
                            if (death_reg != 16'hFFFF) begin
                                death_reg <= death_reg + 16'd1;
                            end
                        end else if (collected_all && player_in_goal) begin
                            state_reg <= S_ADVANCE;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_DEATH: begin
                    if (frame_tick_reg) begin
                        if (tick_seen_reg) begin
                            state_reg     <= S_PLAY;
                            new_level_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                        end else begin
                            tick_seen_reg <= 1'b1;
                        end
                    end
                end
                S_ADVANCE: begin
                    if (level_reg == LAST_LEVEL) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= S_LOAD;
                        level_reg    <= level_reg + 4'd1;
                        rom_addr_reg <= {level_reg + 4'd1, 4'd0};
                        load_cnt_reg <= 5'd0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Player start registers take ROM words 0 and 1.
    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            player_x_reg <= 5'd0;
            player_y_reg <= 5'd0;
        end else if (cap_en) begin
            if (cap_idx == 4'd0) player_x_reg <= rom_data;
            if (cap_idx == 4'd1) player_y_reg <= rom_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_coin
            logic [4:0] coin_x_reg;
            logic [4:0] coin_y_reg;

            // Coin gi takes ROM words 2+2*gi (x) and 3+2*gi (y); off-screen values pass untouched.
            always_ff @(posedge Clk or negedge RESET_N) begin
                if (!RESET_N) begin
                    coin_x_reg <= 5'd0;
                    coin_y_reg <= 5'd0;
                end else if (cap_en) begin
                    if (cap_idx == 4'(2 + 2 * gi)) coin_x_reg <= rom_data;
                    if (cap_idx == 4'(3 + 2 * gi)) coin_y_reg <= rom_data;
                end
            end

            assign coin_start_x[5*gi +: 5] = coin_x_reg;
            assign coin_start_y[5*gi +: 5] = coin_y_reg;
        end
    endgenerate

    assign rom_addr         = rom_addr_reg;
    assign player_start_x   = player_x_reg;
    assign player_start_y   = player_y_reg;
    assign initialize_level = init_reg;
    assign new_level        = new_level_reg;
    assign level_num        = level_reg;
    assign death_count      = death_reg;
    assign busy             = busy_reg;
    assign game_complete    = done_reg;

endmodule
